// File: rtl/tick_checker.sv
// Measures clk cycles between tick_in pulses, tracks lock against modulus M, and
// streams each period over valid/ready. Optional TICK_CHECK_TOL_EN widens the match window by TOL.
module tick_checker #(
  parameter int M          = 10,
  parameter int LOCK_COUNT = 3,
  parameter int TOL        = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tick_in,
  input  logic                        err_clr,
  input  logic                        period_ready,
  output logic [$clog2(2*M+1)-1:0]    period,
  output logic                        period_valid,
  output logic                        locked,
  output logic                        err_period,
  output logic                        err_timeout,
  output logic                        overrun
);

  // state     | meaning
  // S_IDLE    | waiting for a first tick; nothing to measure yet
  // S_ACQUIRE | measuring, counting consecutive matching periods
  // S_LOCKED  | LOCK_COUNT matches seen; mismatch raises err_period
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam int W  = $clog2(2*M+1);
  localparam int MW = $clog2(LOCK_COUNT+1);

  localparam logic [W-1:0]  M_W       = W'(M);
  localparam logic [W-1:0]  CNT_SAT   = W'(2*M);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT-1);

  state_t          state;
  logic [W-1:0]    cnt;
  logic [MW-1:0]   match;
  logic            is_match;
  logic            emit;
  logic            timeout_hit;

`ifdef TICK_CHECK_TOL_EN
  localparam int LO_I = (M - TOL < 1) ? 1 : M - TOL;
  localparam int HI_I = M + TOL;
  logic [31:0] cnt_ext;
  assign cnt_ext  = 32'(cnt);
  assign is_match = (cnt_ext >= 32'(LO_I)) && (cnt_ext <= 32'(HI_I));
`else
  localparam int unused_tol = TOL;
  assign is_match = (cnt == M_W);
`endif

  // cnt already equals the elapsed period in the cycle the next tick arrives
  assign emit        = tick_in && (state != S_IDLE);
  assign timeout_hit = !tick_in && (state != S_IDLE) && (cnt == CNT_SAT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_period   <= 1'b0;
      err_timeout  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (tick_in)
        cnt <= W'(1);
      else if (cnt != CNT_SAT)
        cnt <= cnt + W'(1);

      // clear first so a same-cycle set event below takes priority
      if (err_clr) begin
        err_period  <= 1'b0;
        err_timeout <= 1'b0;
        overrun     <= 1'b0;
      end

      if (period_valid && period_ready)
        period_valid <= 1'b0;

      if (emit) begin
        period       <= cnt;
        period_valid <= 1'b1;
        if (period_valid && !period_ready)
          overrun <= 1'b1;
      end

      if (timeout_hit) begin
        err_timeout <= 1'b1;
        state       <= S_IDLE;
        locked      <= 1'b0;
        match       <= '0;
      end

      case (state)
        S_IDLE: begin
          if (tick_in) begin
            state <= S_ACQUIRE;
            match <= '0;
          end
        end
        S_ACQUIRE: begin
          if (tick_in) begin
            if (is_match) begin
              match <= match + MW'(1);
              if (match == LOCK_LAST) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match <= '0;
            end
          end
        end
        S_LOCKED: begin
          if (tick_in && !is_match) begin
            err_period <= 1'b1;
            state      <= S_ACQUIRE;
            locked     <= 1'b0;
            match      <= '0;
          end
        end
        default: begin
          state  <= S_IDLE;
          locked <= 1'b0;
          match  <= '0;
        end
      endcase
    end
  end

endmodule
